// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 54;
    localparam int unsigned DEFAULT_AE_LEVEL   = 2;
    localparam int unsigned DEFAULT_AF_MARGIN  = 2;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module sfifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 54,
    parameter int unsigned AW         = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read modes,
// threshold flags, occupancy count and sticky error flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned FWFT       = FWFT_OFF,
    parameter int unsigned AF_LEVEL   = DEPTH - DEFAULT_AF_MARGIN,
    parameter int unsigned AE_LEVEL   = DEFAULT_AE_LEVEL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_LVL  = CW'(AE_LEVEL);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be at least 2");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [PW-1:0]         r_wr_ptr, r_rd_ptr, w_wr_ptr_inc, w_rd_ptr_inc;
    logic [CW-1:0]         r_count, w_count_next;
    logic                  r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;
    logic                  w_wr_acc, w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Accept decisions use the registered (pre-edge) flags.
    assign w_wr_acc = w_en && !r_full;
    assign w_rd_acc = r_en && !r_empty;

    assign w_wr_ptr_inc = (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
    assign w_count_next = r_count + {{(CW-1){1'b0}}, w_wr_acc} - {{(CW-1){1'b0}}, w_rd_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_MAX);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= AF_LVL);
            r_aempty <= (w_count_next <= AE_LVL);
            if (w_en && r_full)  r_ovf <= 1'b1;
            if (r_en && r_empty) r_udf <= 1'b1;
        end
    end

    sfifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head word is shown directly; masked while empty so reset reads back zero.
        assign data_out = r_empty ? '0 : w_rdata;
        assign rd_valid = !r_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_rd_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout     <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) r_dout <= w_rdata;
            end
        end

        assign data_out = r_dout;
        assign rd_valid = r_rd_valid;
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT instance share the stimulus.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] d0_dout, d1_dout;
    logic [5:0] d0_count, d1_count;
    logic d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
    logic d1_rv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo #(.FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(d0_dout), .rd_valid(d0_rv), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .overflow(d0_ovf), .underflow(d0_udf)
    );

    sync_fifo #(.FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(d1_dout), .rd_valid(d1_rv), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .overflow(d1_ovf), .underflow(d1_udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        step();
        check("rst_count", 32'(d0_count), 0);
        check("rst_empty", 32'(d0_empty), 1);
        check("rst_full", 32'(d0_full), 0);
        check("rst_ae", 32'(d0_ae), 1);
        check("rst_af", 32'(d0_af), 0);
        check("rst_ovf", 32'(d0_ovf), 0);
        check("rst_udf", 32'(d0_udf), 0);
        check("rst_dout", 32'(d0_dout), 0);
        check("rst_rv", 32'(d0_rv), 0);

        // Fill 0x01..0x36
        for (int i = 1; i <= 54; i++) begin
            w_en = 1'b1; data_in = 8'(i);
            step();
            check("fill_count", 32'(d0_count), 32'(i));
            check("fill_af", 32'(d0_af), 32'(i >= 52));
            check("fill_full", 32'(d0_full), 32'(i == 54));
            check("fill_ae", 32'(d0_ae), 32'(i <= 2));
        end
        data_in = 8'h55;
        step();
        w_en = 1'b0;
        check("ovf_set", 32'(d0_ovf), 1);
        check("ovf_count", 32'(d0_count), 54);

        // Drain in order
        for (int i = 1; i <= 54; i++) begin
            r_en = 1'b1;
            step();
            check("drain_dout", 32'(d0_dout), 32'(i));
            check("drain_rv", 32'(d0_rv), 1);
            check("drain_count", 32'(d0_count), 32'(54 - i));
            check("drain_empty", 32'(d0_empty), 32'(i == 54));
        end
        r_en = 1'b0;
        step();
        check("idle_rv", 32'(d0_rv), 0);
        check("idle_hold", 32'(d0_dout), 32'h36);
        check("pre_udf", 32'(d0_udf), 0);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        check("udf_set", 32'(d0_udf), 1);
        check("udf_rv", 32'(d0_rv), 0);
        check("udf_count", 32'(d0_count), 0);

        // Simultaneous at empty: write taken, read rejected
        do_reset();
        w_en = 1'b1; r_en = 1'b1; data_in = 8'h11;
        step();
        check("se_count", 32'(d0_count), 1);
        check("se_udf", 32'(d0_udf), 1);
        check("se_empty", 32'(d0_empty), 0);
        check("se_rv", 32'(d0_rv), 0);
        r_en = 1'b0;
        for (int i = 0; i < 53; i++) begin
            data_in = 8'(8'h12 + i);
            step();
        end
        check("sf_pre_full", 32'(d0_full), 1);
        check("sf_pre_ovf", 32'(d0_ovf), 0);
        // Simultaneous at full: read taken, write rejected
        r_en = 1'b1; data_in = 8'h99;
        step();
        w_en = 1'b0; r_en = 1'b0;
        check("sf_count", 32'(d0_count), 53);
        check("sf_ovf", 32'(d0_ovf), 1);
        check("sf_full", 32'(d0_full), 0);
        check("sf_dout", 32'(d0_dout), 32'h11);
        check("sf_rv", 32'(d0_rv), 1);

        // Wrap-around at count 10
        do_reset();
        for (int k = 0; k < 10; k++) begin
            w_en = 1'b1; data_in = 8'(k);
            step();
        end
        check("wrap_pre", 32'(d0_count), 10);
        for (int j = 0; j < 200; j++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'(10 + j);
            step();
            check("wrap_count", 32'(d0_count), 10);
            check("wrap_dout", 32'(d0_dout), 32'(j));
        end
        w_en = 1'b0; r_en = 1'b0;

        // FWFT instance
        do_reset();
        check("fw_rst_rv", 32'(d1_rv), 0);
        check("fw_rst_dout", 32'(d1_dout), 0);
        w_en = 1'b1; data_in = 8'hA5;
        step();
        w_en = 1'b0;
        check("fw_dout", 32'(d1_dout), 32'hA5);
        check("fw_rv", 32'(d1_rv), 1);
        check("fw_empty", 32'(d1_empty), 0);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        check("fw_pop_empty", 32'(d1_empty), 1);
        check("fw_pop_rv", 32'(d1_rv), 0);
        check("fw_pop_count", 32'(d1_count), 0);

        // Reset mid-operation at count 30 with overflow set
        do_reset();
        w_en = 1'b1;
        for (int i = 0; i < 55; i++) begin
            data_in = 8'(8'h40 + i);
            step();
        end
        w_en = 1'b0; r_en = 1'b1;
        for (int i = 0; i < 24; i++) step();
        r_en = 1'b0;
        check("mr_pre_count", 32'(d0_count), 30);
        check("mr_pre_ovf", 32'(d0_ovf), 1);
        check("mr_pre_dout", 32'(d0_dout), 32'h57);
        rst = 1'b1; w_en = 1'b1; data_in = 8'hEE;
        step();
        rst = 1'b0; w_en = 1'b0;
        check("mr_count", 32'(d0_count), 0);
        check("mr_empty", 32'(d0_empty), 1);
        check("mr_ovf", 32'(d0_ovf), 0);
        check("mr_dout", 32'(d0_dout), 0);
        step();
        check("mr_ignored", 32'(d0_count), 0);
        check("mr_fw_empty", 32'(d1_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
